// File: rtl/ins_mem_loader_if.sv
// Byte-stream input, instruction-memory write port and status flags of the
// instruction-memory loader, bundled so producer and loader share one handle.
interface ins_mem_loader_if;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        err;

   // Stream producer / supervisor side.
   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
   );

   // Loader side.
   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
   );
endinterface

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: receives a length byte, N big-endian 32-bit words
// and an XOR checksum byte over a valid/ready byte stream, writes each word to
// BASE_ADDR + 4*i, then releases the CPU (cpu_reset=1) if the checksum matches.
// Every output is a register loaded from the next-state value, so the flags
// always describe the state the FSM is currently in.
module ins_mem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic             CLK,
   input logic             Reset,
   ins_mem_loader_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, RUN, ERROR} state_t;

   state_t      stateReg;
   state_t      stateNext;
   logic [7:0]  wordCountReg;   // N from the LEN byte
   logic [7:0]  wordIdxReg;     // index of the word being assembled/written
   logic [1:0]  byteCntReg;     // byte position inside the current word
   logic [7:0]  checksumReg;    // running XOR of DATA bytes
   logic [23:0] partialReg;     // first three bytes of the current word
   logic        accept;
   logic [8:0]  idxPlusOne;

   assign accept     = bus.byte_valid && bus.byte_ready;
   assign idxPlusOne = {1'b0, wordIdxReg} + 9'd1;

   // Next-state decision; stalls (no accepted byte) simply hold the state.
   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         IDLE, RUN, ERROR: if (bus.start) stateNext = LEN;
         LEN:   if (accept) stateNext = (bus.byte_data == 8'h00) ? CHK : DATA;
         DATA:  if (accept && byteCntReg == 2'd3) stateNext = WRITE;
         WRITE: stateNext = (idxPlusOne < {1'b0, wordCountReg}) ? DATA : CHK;
         CHK:   if (accept) stateNext = (bus.byte_data == checksumReg) ? RUN : ERROR;
         default: stateNext = IDLE;
      endcase
   end

   // State, datapath and registered outputs (outputs follow stateNext).
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         stateReg       <= IDLE;
         wordCountReg   <= 8'd0;
         wordIdxReg     <= 8'd0;
         byteCntReg     <= 2'd0;
         checksumReg    <= 8'd0;
         partialReg     <= 24'd0;
         bus.byte_ready <= 1'b0;
         bus.busy       <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= BASE_ADDR;
         bus.mem_wdata  <= 32'd0;
         bus.cpu_reset  <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         stateReg       <= stateNext;
         bus.byte_ready <= (stateNext == LEN) || (stateNext == DATA) || (stateNext == CHK);
         bus.busy       <= (stateNext == LEN) || (stateNext == DATA) ||
                           (stateNext == WRITE) || (stateNext == CHK);
         bus.mem_we     <= (stateNext == WRITE);
         bus.cpu_reset  <= (stateNext == RUN);
         bus.done       <= (stateNext == RUN);
         bus.err        <= (stateNext == ERROR);

         case (stateReg)
            IDLE, RUN, ERROR: begin
               if (bus.start) begin
                  wordCountReg <= 8'd0;
                  wordIdxReg   <= 8'd0;
                  byteCntReg   <= 2'd0;
                  checksumReg  <= 8'd0;
               end
            end
            LEN: begin
               if (accept) wordCountReg <= bus.byte_data;
            end
            DATA: begin
               if (accept) begin
                  partialReg  <= {partialReg[15:0], bus.byte_data};
                  checksumReg <= checksumReg ^ bus.byte_data;
                  byteCntReg  <= byteCntReg + 2'd1;
                  // Fourth byte: present the word and address during WRITE.
                  if (byteCntReg == 2'd3) begin
                     bus.mem_wdata <= {partialReg, bus.byte_data};
                     bus.mem_addr  <= BASE_ADDR + {22'd0, wordIdxReg, 2'b00};
                  end
               end
            end
            WRITE: begin
               wordIdxReg <= wordIdxReg + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader. Two loaders (base 0x0 and base 0x100)
// receive the same byte stream; expected writes are queued per loader when a
// word is about to be sent and popped by a monitor whenever mem_we is seen.
module tb_ins_mem_loader;

   logic CLK = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;

   logic [63:0] exp0 [$];
   logic [63:0] exp1 [$];
   logic [63:0] pop0;
   logic [63:0] pop1;
   logic [31:0] words [0:1];

   ins_mem_loader_if bus0 ();
   ins_mem_loader_if bus1 ();

   ins_mem_loader #(.BASE_ADDR(32'h0000_0000)) dut0 (.CLK(CLK), .Reset(Reset), .bus(bus0.slave));
   ins_mem_loader #(.BASE_ADDR(32'h0000_0100)) dut1 (.CLK(CLK), .Reset(Reset), .bus(bus1.slave));

   assign bus1.start      = bus0.start;
   assign bus1.byte_valid = bus0.byte_valid;
   assign bus1.byte_data  = bus0.byte_data;

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Write monitors: every mem_we must match the oldest expected write.
   always @(negedge CLK) begin
      if (bus0.mem_we === 1'b1) begin
         check("wr0_byte_ready", {31'd0, bus0.byte_ready}, 32'd0);
         check("wr0_cpu_reset", {31'd0, bus0.cpu_reset}, 32'd0);
         check("wr0_expected", {31'd0, exp0.size() != 0}, 32'd1);
         if (exp0.size() != 0) begin
            pop0 = exp0.pop_front();
            check("wr0_addr", bus0.mem_addr, pop0[63:32]);
            check("wr0_data", bus0.mem_wdata, pop0[31:0]);
            $display("write dut0 addr=%h data=%h", bus0.mem_addr, bus0.mem_wdata);
         end
      end
   end

   always @(negedge CLK) begin
      if (bus1.mem_we === 1'b1) begin
         check("wr1_byte_ready", {31'd0, bus1.byte_ready}, 32'd0);
         check("wr1_expected", {31'd0, exp1.size() != 0}, 32'd1);
         if (exp1.size() != 0) begin
            pop1 = exp1.pop_front();
            check("wr1_addr", bus1.mem_addr, pop1[63:32]);
            check("wr1_data", bus1.mem_wdata, pop1[31:0]);
            $display("write dut1 addr=%h data=%h", bus1.mem_addr, bus1.mem_wdata);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulseStart();
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
   endtask

   // Offer one byte, hold it until accepted (bounded), then idle 'gap' cycles.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      bus0.byte_data  = b;
      bus0.byte_valid = 1'b1;
      while (bus0.byte_ready !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      check("byte_ready_wait", {31'd0, bus0.byte_ready}, 32'd1);
      tick();
      bus0.byte_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic queueWord(input int k, input logic [31:0] w);
      logic [31:0] a;
      a = 32'(k) << 2;
      exp0.push_back({a, w});
      exp1.push_back({32'h0000_0100 + a, w});
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, "_busy"}, {31'd0, bus0.busy}, 32'd0);
      check({tag, "_ready"}, {31'd0, bus0.byte_ready}, 32'd0);
      check({tag, "_we"}, {31'd0, bus0.mem_we}, 32'd0);
      check({tag, "_cpu_reset"}, {31'd0, bus0.cpu_reset}, 32'd0);
      check({tag, "_done"}, {31'd0, bus0.done}, 32'd0);
      check({tag, "_err"}, {31'd0, bus0.err}, 32'd0);
   endtask

   // Full load: start, length, nWords words, checksum (model XOR or a bad byte).
   task automatic load(input int nWords, input bit badChk, input int gap);
      logic [7:0]  chk;
      logic [31:0] w;
      chk = 8'h00;
      pulseStart();
      check("start_busy", {31'd0, bus0.busy}, 32'd1);
      check("start_cpu_reset", {31'd0, bus0.cpu_reset}, 32'd0);
      check("start_err", {31'd0, bus0.err}, 32'd0);
      sendByte(nWords[7:0], 0);
      for (int k = 0; k < nWords; k++) begin
         w = words[k];
         queueWord(k, w);
         for (int j = 3; j >= 0; j--) begin
            sendByte(w[8*j +: 8], gap);
            chk = chk ^ w[8*j +: 8];
         end
      end
      sendByte(badChk ? 8'h05 : chk, 0);
      check("end_busy", {31'd0, bus0.busy}, 32'd0);
      check("end_done", {31'd0, bus0.done}, {31'd0, !badChk});
      check("end_err", {31'd0, bus0.err}, {31'd0, badChk});
      check("end_cpu_reset", {31'd0, bus0.cpu_reset}, {31'd0, !badChk});
      check("end_dut1_done", {31'd0, bus1.done}, {31'd0, !badChk});
      check("end_pending0", exp0.size(), 32'd0);
      check("end_pending1", exp1.size(), 32'd0);
      $display("load n=%0d badChk=%0d gap=%0d done=%0b err=%0b", nWords, badChk, gap, bus0.done, bus0.err);
   endtask

   initial begin
      words[0]        = 32'h2001_0005;
      words[1]        = 32'h0021_1020;
      Reset           = 1'b1;
      bus0.start      = 1'b0;
      bus0.byte_valid = 1'b0;
      bus0.byte_data  = 8'h00;
      tick();
      tick();
      checkIdleOutputs("reset");
      check("reset_addr0", bus0.mem_addr, 32'h0000_0000);
      check("reset_addr1", bus1.mem_addr, 32'h0000_0100);
      check("reset_wdata", bus0.mem_wdata, 32'h0);
      Reset = 1'b0;
      repeat (4) tick();
      checkIdleOutputs("post_reset_idle");

      load(2, 1'b0, 0);   // two words, good checksum -> RUN
      load(2, 1'b1, 0);   // restarted from RUN, bad checksum -> ERROR
      load(0, 1'b0, 0);   // empty image from ERROR -> RUN
      load(2, 1'b0, 1);   // byte_valid toggling during DATA

      // Abort after the sixth byte: first word written, second never.
      pulseStart();
      sendByte(8'h02, 0);
      queueWord(0, words[0]);
      for (int j = 3; j >= 0; j--) sendByte(words[0][8*j +: 8], 0);
      sendByte(words[1][31:24], 0);
      Reset = 1'b1;
      #2;
      checkIdleOutputs("async_reset");
      check("async_reset_addr0", bus0.mem_addr, 32'h0000_0000);
      check("async_reset_wdata", bus0.mem_wdata, 32'h0);
      tick();
      Reset = 1'b0;
      repeat (5) tick();
      checkIdleOutputs("after_abort");
      check("abort_pending0", exp0.size(), 32'd0);

      load(2, 1'b0, 0);   // full reload after the abort

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
